hack_data_memory: RTL
=====================

Name: hack_data_memory

Overview:
Data-memory responder on the CPU's memory port. It decodes addrM, accepts writes of outM when writeM is high, and returns read data on inM in the same cycle. It maps three regions: data RAM, a screen buffer, and a keyboard register. It also contains a screen scanout engine that streams screen pixels over a valid/ready interface, and a keyboard capture register loaded through a valid/ready handshake.

Parameters:
RAM_AW, 14, RAM address width; the block holds 2^RAM_AW words and RAM_AW must be 14 or less.
SCR_WPR, 32, screen words per row (512 pixels per row).
SCR_ROWS, 256, screen rows held in the buffer; benches may reduce this for short frames.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous reset, active-high.
addrM  in  16  CPU data address.
outM  in  16  CPU write data.
writeM  in  1  CPU write strobe.
inM  out  16  read data for addrM (combinational).
kbd_valid  in  1  keyboard source has a code.
kbd_code  in  16  key code; 0 means no key pressed.
kbd_ready  out  1  block can accept a code.
scan_en  in  1  enables screen scanout.
pix_data  out  1  current pixel, 1 = black.
pix_valid  out  1  pix_data is valid.
pix_ready  in  1  sink accepts the pixel.
pix_first  out  1  marks pixel 0 of row 0; qualified by pix_valid.
pix_eol  out  1  marks the last pixel of a row; qualified by pix_valid.

Behaviour:
- Address decode:
  - 0x0000-0x3FFF: RAM, indexed by addrM[RAM_AW-1:0]; upper address bits are ignored (aliasing).
  - 0x4000-0x5FFF: screen, indexed by addrM[12:0]. Row = index/SCR_WPR, column = index%SCR_WPR.
  - 0x6000: keyboard register; read-only, so writes are ignored.
  - All other addresses (0x6001-0xFFFF): inM = 0, writes ignored.
  - Screen indices with row >= SCR_ROWS: inM = 0, writes ignored.
- Reads: asynchronous. inM follows addrM and array contents with zero cycles of latency.
- Writes: when writeM = 1, the target word is updated at the rising edge. A read of the same address returns the old value in that cycle and the new value in the next.
- Keyboard:
  - kbd_ready = 1 whenever reset = 0; kbd_ready = 0 during reset.
  - On kbd_valid && kbd_ready, kbd_reg <= kbd_code at the edge. The CPU sees the new value the next cycle.
  - kbd_reg holds its value until the next transfer.
- Reset:
  - kbd_reg = 0, scanout state = IDLE, scan_addr = 0, bit_cnt = 0.
  - pix_valid = 0, pix_data = 0, pix_first = 0, pix_eol = 0.
  - RAM and screen contents are NOT cleared.
  - Reset asserted mid-operation aborts the scan immediately. The next frame starts at word 0.
- Scanout FSM:
  - IDLE: pix_valid = 0. If scan_en = 1, go to LOAD.
  - LOAD (one cycle): shreg <= screen[scan_addr], bit_cnt <= 0, go to SHIFT. pix_valid = 0, giving a one-cycle bubble per word.
  - SHIFT:
    - Outputs: pix_valid = 1 and pix_data = shreg[0]. Bit 0 is the leftmost pixel, sent LSB first.
    - On pix_ready: shreg >>= 1 and bit_cnt++.
    - When pix_ready is accepted with bit_cnt = 15:
      - scan_addr advances, wrapping to 0 after SCR_ROWS*SCR_WPR-1.
      - If the wrap occurred and scan_en = 0, go to IDLE; otherwise go to LOAD.
    - Deasserting scan_en mid-frame completes the current frame before the FSM idles.
  - While pix_valid && !pix_ready: pix_data, pix_first and pix_eol are held stable.
- Markers:
  - pix_first = 1 only while scan_addr = 0 and bit_cnt = 0.
  - pix_eol = 1 while bit_cnt = 15 and scan_addr%SCR_WPR = SCR_WPR-1.
- Collision: if the CPU writes screen[scan_addr] in the LOAD cycle, shreg captures the old word (read-before-write). The new word appears in the next frame.
- Counters:
  - scan_addr is 13 bits.
  - bit_cnt is 4 bits.
  - All arithmetic is unsigned with explicit wrap.

Test Plan:
- RAM write/read: write 0x1234 to 0x0010 then 0xBEEF to 0x3FFF; read both back. Reading 0x0010 in the write cycle returns the prior value. Then inM = 0x1234 and 0xBEEF.
- Decode boundaries:
  - Write 0xFFFF to 0x6000, 0x6001 and 0x8000; all reads return 0, with kbd_reg = 0.
  - Write 0x00AA to 0x4000 with SCR_ROWS = 2, SCR_WPR = 2; read gives 0x00AA.
  - Access 0x4004 (row 2): read gives 0, and the write is ignored.
- Keyboard: kbd_valid = 1 with code 0x0083 for one cycle; the next cycle the CPU reads 0x6000 = 0x0083. Send code 0; the read returns 0. With reset = 1, kbd_ready = 0.
- Scanout, SCR_ROWS = 2, SCR_WPR = 2:
  - Load screen words 0x0001, 0x8000, 0xFFFF, 0x0000.
  - Enable scanout with pix_ready = 1.
  - Stream: 1,0×15 | 0×15,1 | 1×16 | 0×16, with a one-cycle bubble between words.
  - pix_first is set on the first pixel only; pix_eol on pixels 31 and 63.
  - After scan_en drops, the stream wraps, finishes the current frame, then idles.
- Backpressure: hold pix_ready = 0 for 5 cycles mid-word. pix_valid stays 1 and pix_data is unchanged; no pixel is lost or duplicated.
- Reset mid-scan: assert reset at pixel 20 of the frame. The next cycle pix_valid = 0. After release with scan_en = 1, the first pixel carries pix_first and word 0's bit 0. RAM and screen contents are unchanged.

Source files
------------

// File: rtl/hack_data_memory_if.sv
// CPU memory port, keyboard handshake and pixel stream of the Hack data memory.
interface hack_data_memory_if;
    logic [15:0] addrM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic        scan_en;
    logic        pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_first;
    logic        pix_eol;

    modport master (
        output addrM, outM, writeM, kbd_valid, kbd_code, scan_en, pix_ready,
        input  inM, kbd_ready, pix_data, pix_valid, pix_first, pix_eol
    );
    modport slave (
        input  addrM, outM, writeM, kbd_valid, kbd_code, scan_en, pix_ready,
        output inM, kbd_ready, pix_data, pix_valid, pix_first, pix_eol
    );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen buffer and keyboard register on the CPU port,
// plus a screen scanout engine streaming pixels LSB-first over valid/ready.
module hack_data_memory #(
    parameter int RAM_AW   = 14,
    parameter int SCR_WPR  = 32,
    parameter int SCR_ROWS = 256
) (
    input logic              clk,
    input logic              reset,
    hack_data_memory_if.slave bus
);
    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int SCR_WORDS = SCR_ROWS * SCR_WPR;
    localparam int SCR_IW    = (SCR_WORDS > 1) ? $clog2(SCR_WORDS) : 1;
    localparam int COL_W     = (SCR_WPR > 1) ? $clog2(SCR_WPR) : 1;
    localparam logic [13:0]      SCR_LIMIT = 14'(SCR_WORDS);
    localparam logic [12:0]      SCR_LAST  = 13'(SCR_WORDS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SCR_WPR - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} scanState_t;

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] screen [SCR_WORDS];

    scanState_t       state, stateNext;
    logic [12:0]      scanAddr;
    logic [COL_W-1:0] scanCol;
    logic [3:0]       bitCnt;
    logic [15:0]      shreg;
    logic [15:0]      kbdReg;

    logic [12:0] scrIdx;
    logic        ramHit, scrHit, kbdHit;
    logic        pixAcc, wordDone, lastWord;

    // Screen rows past SCR_ROWS are unmapped, so the range check keeps them from aliasing.
    assign scrIdx = bus.addrM[12:0];
    assign ramHit = (bus.addrM[15:14] == 2'b00);
    assign scrHit = (bus.addrM[15:13] == 3'b010) && ({1'b0, scrIdx} < SCR_LIMIT);
    assign kbdHit = (bus.addrM == 16'h6000);

    always_comb begin
        bus.inM = 16'h0000;
        if (ramHit)      bus.inM = ram[bus.addrM[RAM_AW-1:0]];
        else if (scrHit) bus.inM = screen[scrIdx[SCR_IW-1:0]];
        else if (kbdHit) bus.inM = kbdReg;
    end

    always_ff @(posedge clk) begin
        if (bus.writeM && ramHit) ram[bus.addrM[RAM_AW-1:0]] <= bus.outM;
        if (bus.writeM && scrHit) screen[scrIdx[SCR_IW-1:0]] <= bus.outM;
    end

    assign bus.kbd_ready = !reset;

    assign pixAcc   = (state == SHIFT) && bus.pix_ready;
    assign wordDone = pixAcc && (bitCnt == 4'd15);
    assign lastWord = (scanAddr == SCR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            scanAddr <= '0;
            scanCol  <= '0;
            bitCnt   <= '0;
            shreg    <= '0;
            kbdReg   <= '0;
        end else begin
            state <= stateNext;
            if (bus.kbd_valid) kbdReg <= bus.kbd_code;
            // LOAD samples the array before any same-edge CPU write lands.
            if (state == LOAD) begin
                shreg  <= screen[scanAddr[SCR_IW-1:0]];
                bitCnt <= 4'd0;
            end else if (pixAcc) begin
                shreg  <= shreg >> 1;
                bitCnt <= bitCnt + 4'd1;
                if (wordDone) begin
                    scanAddr <= lastWord ? 13'd0 : scanAddr + 13'd1;
                    scanCol  <= (scanCol == COL_LAST) ? '0 : scanCol + COL_W'(1);
                end
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.scan_en) stateNext = LOAD;
            LOAD:    stateNext = SHIFT;
            SHIFT:   if (wordDone) stateNext = (lastWord && !bus.scan_en) ? IDLE : LOAD;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.pix_valid = (state == SHIFT);
    assign bus.pix_data  = (state == SHIFT) && shreg[0];
    assign bus.pix_first = (state == SHIFT) && (scanAddr == 13'd0) && (bitCnt == 4'd0);
    assign bus.pix_eol   = (state == SHIFT) && (bitCnt == 4'd15) && (scanCol == COL_LAST);
endmodule
